// File: rtl/imm_enc_if.sv
// Request/response bundle for the RV32 immediate encoder.
// The master side builds requests and consumes encoded words.
interface imm_enc_if #(
    parameter int IMM_W = 32,
    parameter int CNT_W = 16
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [5:1]       sel_i;
    logic [IMM_W-1:0] imm_i;
    logic [31:0]      base_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      inst_o;
    logic             err_o;
    logic [CNT_W-1:0] enc_cnt_o;
    logic [CNT_W-1:0] err_cnt_o;

    modport master (
        output in_valid_i, sel_i, imm_i, base_i, out_ready_i,
        input  in_ready_o, out_valid_o, inst_o, err_o, enc_cnt_o, err_cnt_o
    );

    modport slave (
        input  in_valid_i, sel_i, imm_i, base_i, out_ready_i,
        output in_ready_o, out_valid_o, inst_o, err_o, enc_cnt_o, err_cnt_o
    );
endinterface

// File: rtl/imm_enc.sv
// RV32 immediate encoder: packs a sign-extended immediate into I/S/B/U/J fields and flags
// unrepresentable values, through a 2-entry output FIFO. IMM_W must be >= 21.
// Statistics counters are built only with YSYX_23060251_IMM_ENC_CNT_EN defined.
module imm_enc #(
    parameter int IMM_W = 32,
    parameter int CNT_W = 16
) (
    input logic        clk_i,
    input logic        rst_i,
    imm_enc_if.slave   bus
);

    localparam logic [31:0] MASK_I = 32'hFFF0_0000;
    localparam logic [31:0] MASK_S = 32'hFE00_0F80;
    localparam logic [31:0] MASK_B = 32'hFE00_0F80;
    localparam logic [31:0] MASK_U = 32'hFFFF_F000;
    localparam logic [31:0] MASK_J = 32'hFFFF_F000;

    logic [IMM_W-1:0] imm;
    logic [31:0]      imm32;
    logic [5:1]       sel;
    logic             fit12;
    logic             fit13;
    logic             fit21;
    logic             u_hi_ok;
    logic             range_ok;
    logic [31:0]      mask;
    logic [31:0]      enc;
    logic             enc_err;
    logic [31:0]      enc_inst;

    assign imm = bus.imm_i;
    assign sel = bus.sel_i;

    // Only the low 32 bits of a wider immediate land in the instruction word.
    if (IMM_W >= 32) begin : g_imm_wide
        assign imm32 = imm[31:0];
    end else begin : g_imm_narrow
        assign imm32 = {{(32-IMM_W){imm[IMM_W-1]}}, imm};
    end

    if (IMM_W > 32) begin : g_u_hi
        assign u_hi_ok = (&imm[IMM_W-1:31]) | ~(|imm[IMM_W-1:31]);
    end else begin : g_u_no_hi
        assign u_hi_ok = 1'b1;
    end

    // A value fits an N-bit signed field when every bit from N-1 upward equals the sign.
    assign fit12 = (&imm[IMM_W-1:11]) | ~(|imm[IMM_W-1:11]);
    assign fit13 = (&imm[IMM_W-1:12]) | ~(|imm[IMM_W-1:12]);
    assign fit21 = (&imm[IMM_W-1:20]) | ~(|imm[IMM_W-1:20]);

    always_comb begin
        range_ok = 1'b0;
        enc      = '0;
        mask     = '0;

        // Illegal multi-hot selects clear the union of their immediate fields.
        if (sel[1]) mask = mask | MASK_I;
        if (sel[2]) mask = mask | MASK_S;
        if (sel[3]) mask = mask | MASK_B;
        if (sel[4]) mask = mask | MASK_U;
        if (sel[5]) mask = mask | MASK_J;

        case (sel)
            5'b00001: begin
                range_ok = fit12;
                enc      = {imm32[11:0], 20'b0};
            end
            5'b00010: begin
                range_ok = fit12;
                enc      = {imm32[11:5], 13'b0, imm32[4:0], 7'b0};
            end
            5'b00100: begin
                range_ok = fit13 & ~imm[0];
                enc      = {imm32[12], imm32[10:5], 13'b0, imm32[4:1], imm32[11], 7'b0};
            end
            5'b01000: begin
                range_ok = ~(|imm[11:0]) & u_hi_ok;
                enc      = {imm32[31:12], 12'b0};
            end
            5'b10000: begin
                range_ok = fit21 & ~imm[0];
                enc      = {imm32[20], imm32[10:1], imm32[11], imm32[19:12], 12'b0};
            end
            default: begin
                range_ok = 1'b0;
                enc      = '0;
            end
        endcase
    end

    assign enc_err  = ~range_ok;
    assign enc_inst = (bus.base_i & ~mask) | (enc_err ? 32'b0 : enc);

    logic [32:0] mem_q [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  cnt_q;
    logic        in_ready;
    logic        out_valid;
    logic        push;
    logic        pop;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign push      = bus.in_valid_i & in_ready;
    assign pop       = out_valid & bus.out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {enc_err, enc_inst};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.inst_o      = mem_q[rd_ptr_q][31:0];
    assign bus.err_o       = mem_q[rd_ptr_q][32];

`ifdef YSYX_23060251_IMM_ENC_CNT_EN
    logic [CNT_W-1:0] enc_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;

    // Counters saturate so a long self-test never reports a wrapped small number.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enc_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (push) begin
            if (~&enc_cnt_q) enc_cnt_q <= enc_cnt_q + 1'b1;
            if (enc_err && ~&err_cnt_q) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.enc_cnt_o = enc_cnt_q;
    assign bus.err_cnt_o = err_cnt_q;
`else
    assign bus.enc_cnt_o = '0;
    assign bus.err_cnt_o = '0;
`endif

endmodule

// File: doc/imm_enc.md
Name: imm_enc

Overview:
- Immediate encoder, the inverse of the immediate generator.
- Packs a sign-extended immediate into the RV32 I/S/B/U/J bit positions of a 32-bit instruction word and checks that the immediate is representable.
- Used by the trace-replay / self-test instruction builder feeding the fetch stub.
- valid/ready on both sides; 2-entry output buffer; 1-cycle latency.

Parameters:
- IMM_W, 32: width of immediate input; must be >= 21.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_valid_i  in  1  request valid
- in_ready_o  out  1  request accepted when in_valid_i & in_ready_o
- sel_i  in  5  type select [5:1]; bit1=I, bit2=S, bit3=B, bit4=U, bit5=J; one-hot required
- imm_i  in  IMM_W  immediate, two's complement
- base_i  in  32  instruction template (opcode, rd, rs1, rs2, funct fields); immediate bit positions ignored
- out_valid_o  out  1  encoded word valid
- out_ready_i  in  1  consumer ready
- inst_o  out  32  encoded instruction
- err_o  out  1  immediate not representable, or sel_i not one-hot
- enc_cnt_o  out  CNT_W  accepted-request count (optional feature)
- err_cnt_o  out  CNT_W  error count (optional feature)

Behaviour:
- Clock and reset: single clock clk_i; rst_i synchronous, active-high.
- Reset values:
  - out_valid_o=0, inst_o=0, err_o=0, counters=0.
  - in_ready_o=1 from the first cycle after reset.
  - Buffer emptied; in-flight entries discarded, even mid-operation.
- Encoding (combinational on input, registered into buffer):
  - I: inst[31:20]=imm[11:0]
  - S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]
  - B: inst[31]=imm[12], inst[7]=imm[11], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1]
  - U: inst[31:12]=imm[31:12]
  - J: inst[31]=imm[20], inst[19:12]=imm[19:12], inst[20]=imm[11], inst[30:21]=imm[10:1]
  - All other bits are copied from base_i.
- Range checks; err=1 if any of the following hold:
  - I/S: imm not in [-2048, 2047].
  - B: imm not in [-4096, 4094], or imm[0]=1.
  - J: imm not in [-1048576, 1048574], or imm[0]=1.
  - U: imm[11:0] != 0; if IMM_W>32, also imm[IMM_W-1:31] not all equal.
  - sel_i zero or multi-hot.
- On err=1: immediate bit positions in inst are forced to 0, non-immediate bits still come from base_i, and the entry is still delivered.
- Round-trip property: for any legal request, the immediate generator applied to inst_o with the same select returns imm_i sign-truncated to 32 bits.
- Buffer:
  - 2-entry FIFO of {inst, err}, in order.
  - in_ready_o = (count < 2); this does not depend on out_ready_i, so there is no combinational in->out path.
  - out_valid_o = (count > 0); inst_o/err_o are driven from the head entry and held stable while out_valid_o & !out_ready_i.
- Latency: a request accepted in cycle N is visible on out_valid_o in cycle N+1 when the buffer was empty.
- Simultaneous push and pop:
  - count unchanged; order preserved.
  - At count=1, the head is replaced by the new entry in the next cycle.
- Full (count=2): in_ready_o=0 even if out_ready_i=1 in the same cycle; push resumes the next cycle.
- Empty: out_ready_i is ignored; no spurious pop.
- Inputs sampled only on accept; changes while in_ready_o=0 have no effect.

Optional Feature:
- Macro: YSYX_23060251_IMM_ENC_CNT_EN.
- Defined:
  - enc_cnt_o increments on every accept.
  - err_cnt_o increments on every accept whose err=1.
  - Both saturate at all-ones (no wrap) and clear on rst_i.
- Undefined: enc_cnt_o and err_cnt_o tied to 0; no counter flops.

Test Plan:
- I-type, base_i=32'h00000013, imm_i=-1, sel=00001 -> inst_o=32'hFFF00013, err_o=0, one cycle after accept.
- B-type, base_i=32'h00000063, imm_i=-4 -> inst_o=32'hFE000EE3, err_o=0. Then imm_i=3 -> err_o=1, inst_o=32'h00000063.
- J-type, base_i=32'h000000EF, imm_i=2048 -> inst_o=32'h001000EF. Then U-type, imm_i=32'h12345000, base_i=32'h00000537 -> inst_o=32'h12345537.
- Backpressure:
  - Hold out_ready_i=0 and push 3 requests -> in_ready_o=0 after 2 accepts; 3rd is held.
  - Release out_ready_i -> outputs in order; 3rd accepted the cycle after the first pop.
- Back-to-back streaming: in_valid_i=1 and out_ready_i=1 for 100 random legal requests -> one output per cycle; all pass the round-trip check against the immediate generator.
- Reset with 2 entries buffered and sel_i=00000 pending -> next cycle out_valid_o=0, in_ready_o=1. With the macro defined, counters read 0 after reset and err_cnt_o=1 after one illegal-select accept.
